// File: rtl/nv_nvdla_cacc_slcg_pkg.sv
// Shared types and defaults for the CACC second-level clock-gating controller.
package nv_nvdla_cacc_slcg_pkg;

   // State encodings as seen on slcg_state
   localparam logic [1:0] SLCG_RUN   = 2'd0;
   localparam logic [1:0] SLCG_HOLD  = 2'd1;
   localparam logic [1:0] SLCG_GATED = 2'd2;
   localparam logic [1:0] SLCG_WAKE  = 2'd3;

   // Default timing and counter widths
   localparam int unsigned IDLE_HYST_DEF = 16;
   localparam int unsigned WAKE_DLY_DEF  = 2;
   localparam int unsigned CNT_W_DEF     = 16;
   localparam int unsigned HCNT_W        = 8;

   typedef enum logic [1:0] {
      ST_RUN   = SLCG_RUN,
      ST_HOLD  = SLCG_HOLD,
      ST_GATED = SLCG_GATED,
      ST_WAKE  = SLCG_WAKE
   } slcg_state_e;

endpackage

// File: rtl/nv_nvdla_cacc_slcg_satcnt.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module nv_nvdla_cacc_slcg_satcnt #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   // Count up, hold at all-ones, clear wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/nv_nvdla_cacc_slcg_ctrl.sv
// SLCG sequencer for the CACC core clock: idle hysteresis, overrides, wake settle.
module nv_nvdla_cacc_slcg_ctrl
   import nv_nvdla_cacc_slcg_pkg::*;
#(
   parameter int unsigned IDLE_HYST = IDLE_HYST_DEF,
   parameter int unsigned WAKE_DLY  = WAKE_DLY_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rst,
   input  logic             slcg_en_src_0,
   input  logic             slcg_en_src_1,
   input  logic             wake_req,
   input  logic             dla_clk_ovr_on_sync,
   input  logic             global_clk_ovr_on_sync,
   input  logic             tmc2slcg_disable_clock_gating,
   input  logic             gated_cnt_clr,
   output logic             clk_en,
   output logic             slcg_ready,
   output logic [1:0]       slcg_state,
   output logic [CNT_W-1:0] gated_cnt
);

   localparam logic [HCNT_W-1:0] HYST_LD = HCNT_W'(IDLE_HYST - 1);
   localparam logic [HCNT_W-1:0] WAKE_LD = HCNT_W'(WAKE_DLY - 1);

   slcg_state_e       state;
   slcg_state_e       state_nxt;
   logic [HCNT_W-1:0] cnt;
   logic [HCNT_W-1:0] cnt_nxt;
   logic              ovr;
   logic              allow;

   assign ovr   = dla_clk_ovr_on_sync | global_clk_ovr_on_sync | tmc2slcg_disable_clock_gating;
   assign allow = slcg_en_src_0 & slcg_en_src_1 & ~ovr & ~wake_req;

   // Next-state and hysteresis/settle counter decode
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_RUN: begin
            if (allow) begin
               state_nxt = ST_HOLD;
               cnt_nxt   = HYST_LD;
            end
         end
         ST_HOLD: begin
            if (!allow) begin
               state_nxt = ST_RUN;
            end else if (cnt == '0) begin
               state_nxt = ST_GATED;
            end else begin
               cnt_nxt = cnt - HCNT_W'(1);
            end
         end
         ST_GATED: begin
            if (!allow) begin
               state_nxt = ST_WAKE;
               cnt_nxt   = WAKE_LD;
            end
         end
         ST_WAKE: begin
            // Settle interval runs to completion regardless of allow
            if (cnt == '0) begin
               state_nxt = ST_RUN;
            end else begin
               cnt_nxt = cnt - HCNT_W'(1);
            end
         end
         default: begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State, counter and Moore outputs registered together
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         state      <= ST_RUN;
         cnt        <= '0;
         clk_en     <= 1'b1;
         slcg_ready <= 1'b1;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         clk_en     <= (state_nxt != ST_GATED);
         slcg_ready <= (state_nxt == ST_RUN) || (state_nxt == ST_HOLD);
      end
   end

   assign slcg_state = state;

   nv_nvdla_cacc_slcg_satcnt #(
      .CNT_W (CNT_W)
   ) u_gated_cnt (
      .clk (nvdla_core_clk),
      .rst (nvdla_core_rst),
      .inc (state == ST_GATED),
      .clr (gated_cnt_clr),
      .cnt (gated_cnt)
   );

endmodule

// File: tb/tb_nv_nvdla_cacc_slcg_ctrl.sv
// Directed bench for the CACC SLCG controller (default, 4-bit counter, and IDLE_HYST=1 instances).
module tb_nv_nvdla_cacc_slcg_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        en0, en1, wake, dla_ovr, glb_ovr, tmc_dis, clr;

   logic        clk_en, ready;
   logic [1:0]  st;
   logic [15:0] gc;

   logic        s_clk_en, s_ready;
   logic [1:0]  s_st;
   logic [3:0]  s_gc;

   logic        h_clk_en, h_ready;
   logic [1:0]  h_st;
   logic [15:0] h_gc;

   int n_chk  = 0;
   int n_pass = 0;
   int exp_gc;

   always #5 clk = ~clk;

   nv_nvdla_cacc_slcg_ctrl u_dut (
      .nvdla_core_clk                (clk),
      .nvdla_core_rst                (rst),
      .slcg_en_src_0                 (en0),
      .slcg_en_src_1                 (en1),
      .wake_req                      (wake),
      .dla_clk_ovr_on_sync           (dla_ovr),
      .global_clk_ovr_on_sync        (glb_ovr),
      .tmc2slcg_disable_clock_gating (tmc_dis),
      .gated_cnt_clr                 (clr),
      .clk_en                        (clk_en),
      .slcg_ready                    (ready),
      .slcg_state                    (st),
      .gated_cnt                     (gc)
   );

   nv_nvdla_cacc_slcg_ctrl #(.CNT_W(4)) u_sat (
      .nvdla_core_clk                (clk),
      .nvdla_core_rst                (rst),
      .slcg_en_src_0                 (en0),
      .slcg_en_src_1                 (en1),
      .wake_req                      (wake),
      .dla_clk_ovr_on_sync           (dla_ovr),
      .global_clk_ovr_on_sync        (glb_ovr),
      .tmc2slcg_disable_clock_gating (tmc_dis),
      .gated_cnt_clr                 (clr),
      .clk_en                        (s_clk_en),
      .slcg_ready                    (s_ready),
      .slcg_state                    (s_st),
      .gated_cnt                     (s_gc)
   );

   nv_nvdla_cacc_slcg_ctrl #(.IDLE_HYST(1), .WAKE_DLY(1)) u_h1 (
      .nvdla_core_clk                (clk),
      .nvdla_core_rst                (rst),
      .slcg_en_src_0                 (en0),
      .slcg_en_src_1                 (en1),
      .wake_req                      (wake),
      .dla_clk_ovr_on_sync           (dla_ovr),
      .global_clk_ovr_on_sync        (glb_ovr),
      .tmc2slcg_disable_clock_gating (tmc_dis),
      .gated_cnt_clr                 (clr),
      .clk_en                        (h_clk_en),
      .slcg_ready                    (h_ready),
      .slcg_state                    (h_st),
      .gated_cnt                     (h_gc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
   endtask

   // Advance n active edges, then sample 1 time unit later
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; en0 = 1'b0; en1 = 1'b0; wake = 1'b0;
      dla_ovr = 1'b0; glb_ovr = 1'b0; tmc_dis = 1'b0; clr = 1'b0;
      step(3);
      chk("rst_clk_en", 32'(clk_en), 1);
      chk("rst_ready",  32'(ready), 1);
      chk("rst_state",  32'(st), 0);
      chk("rst_gc",     32'(gc), 0);
      rst = 1'b0;
      step(1);
      chk("idle_run_state", 32'(st), 0);

      // Idle sources held: gate after 1+16 edges
      en0 = 1'b1; en1 = 1'b1;
      step(1);
      chk("t1_hold_state", 32'(st), 1);
      chk("t1_h1_hold",    32'(h_st), 1);
      step(1);
      chk("t1_h1_gated",   32'(h_st), 2);
      chk("t1_h1_clk_en",  32'(h_clk_en), 0);
      step(14);
      chk("t1_e16_state",  32'(st), 1);
      chk("t1_e16_clk_en", 32'(clk_en), 1);
      step(1);
      chk("t1_e17_state",  32'(st), 2);
      chk("t1_e17_clk_en", 32'(clk_en), 0);
      chk("t1_e17_ready",  32'(ready), 0);
      chk("t1_e17_gc",     32'(gc), 0);
      step(23);
      chk("t1_e40_gc",     32'(gc), 23);
      chk("t5_sat_gc",     32'(s_gc), 15);

      // Single-cycle wake pulse
      wake = 1'b1;
      step(1);
      chk("t2_wake_state",  32'(st), 3);
      chk("t2_wake_clk_en", 32'(clk_en), 1);
      chk("t2_wake_ready",  32'(ready), 0);
      chk("t2_wake_gc",     32'(gc), 24);
      chk("t2_h1_wake",     32'(h_st), 3);
      chk("t2_h1_ready0",   32'(h_ready), 0);
      wake = 1'b0;
      step(1);
      chk("t2_t2_ready",    32'(ready), 0);
      chk("t2_h1_run",      32'(h_st), 0);
      chk("t2_h1_ready1",   32'(h_ready), 1);
      step(1);
      chk("t2_t3_ready",    32'(ready), 1);
      chk("t2_t3_state",    32'(st), 0);
      step(1);
      chk("t2_rehold",      32'(st), 1);
      step(15);
      chk("t2_hold_end",    32'(st), 1);
      chk("t2_hold_clk_en", 32'(clk_en), 1);
      step(1);
      chk("t2_regated",     32'(st), 2);
      chk("t2_gc_frozen",   32'(gc), 24);

      // Non-idle blip in HOLD restarts hysteresis
      wake = 1'b1;
      step(1);
      wake = 1'b0;
      step(2);
      chk("t3_run",         32'(st), 0);
      chk("t3_gc",          32'(gc), 25);
      step(11);
      chk("t3_hold_cnt5",   32'(st), 1);
      en1 = 1'b0;
      step(1);
      chk("t3_back_run",    32'(st), 0);
      chk("t3_clk_en",      32'(clk_en), 1);
      en1 = 1'b1;
      step(16);
      chk("t3_full_hold",   32'(st), 1);
      chk("t3_full_clk_en", 32'(clk_en), 1);
      step(1);
      chk("t3_regated",     32'(st), 2);

      // Each override forces a wake and pins the FSM in RUN
      exp_gc = 25;
      for (int k = 0; k < 3; k++) begin
         dla_ovr = (k == 0); glb_ovr = (k == 1); tmc_dis = (k == 2);
         step(1);
         exp_gc++;
         chk($sformatf("t4_ovr%0d_wake", k),   32'(st), 3);
         chk($sformatf("t4_ovr%0d_clk_en", k), 32'(clk_en), 1);
         chk($sformatf("t4_ovr%0d_gc", k),     32'(gc), 32'(exp_gc));
         step(2);
         chk($sformatf("t4_ovr%0d_run", k),    32'(st), 0);
         step(5);
         chk($sformatf("t4_ovr%0d_held", k),   32'(st), 0);
         chk($sformatf("t4_ovr%0d_frz", k),    32'(gc), 32'(exp_gc));
         dla_ovr = 1'b0; glb_ovr = 1'b0; tmc_dis = 1'b0;
         step(17);
         chk($sformatf("t4_ovr%0d_regate", k), 32'(st), 2);
      end

      // Clear during gating beats the increment
      clr = 1'b1;
      step(1);
      chk("t5_clr_gc",   32'(gc), 0);
      chk("t5_clr_sgc",  32'(s_gc), 0);
      clr = 1'b0;
      step(1);
      chk("t5_gc1",      32'(gc), 1);
      chk("t5_sgc1",     32'(s_gc), 1);
      step(1);
      chk("t5_gc2",      32'(gc), 2);

      // Asynchronous reset mid-GATED, between edges
      #2;
      rst = 1'b1;
      #1;
      chk("t6g_clk_en",  32'(clk_en), 1);
      chk("t6g_ready",   32'(ready), 1);
      chk("t6g_state",   32'(st), 0);
      chk("t6g_gc",      32'(gc), 0);
      #1;
      rst = 1'b0;
      step(17);
      chk("t6_regated",  32'(st), 2);
      wake = 1'b1;
      step(1);
      wake = 1'b0;
      chk("t6_wake",     32'(st), 3);

      // Asynchronous reset mid-WAKE
      #2;
      rst = 1'b1;
      #1;
      chk("t6w_clk_en",  32'(clk_en), 1);
      chk("t6w_ready",   32'(ready), 1);
      chk("t6w_state",   32'(st), 0);
      chk("t6w_gc",      32'(gc), 0);
      #1;
      rst = 1'b0;
      step(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
